// File: rtl/ex_control_pkg.sv
// Shared encodings for the exposure controller and its readout sequencer.
// Main-FSM state, readout sub-state codes and the internal readout step index.
package ex_control_pkg;

    typedef enum logic [1:0] {
        s_IDLE     = 2'b00,
        s_EXPOSURE = 2'b01,
        s_READOUT  = 2'b10
    } main_state_e;

    typedef enum logic [2:0] {
        s_INIT    = 3'b000,
        s_NRE_1   = 3'b001,
        s_ADC_1   = 3'b010,
        s_NOTHING = 3'b011,
        s_NRE_2   = 3'b100,
        s_ADC_2   = 3'b101,
        s_END     = 3'b110
    } sub_state_e;

    typedef enum logic [3:0] {
        STEP_INIT   = 4'd0,
        STEP_NRE1_A = 4'd1,
        STEP_ADC_1  = 4'd2,
        STEP_NRE1_B = 4'd3,
        STEP_GAP    = 4'd4,
        STEP_NRE2_A = 4'd5,
        STEP_ADC_2  = 4'd6,
        STEP_NRE2_B = 4'd7,
        STEP_END    = 4'd8
    } step_e;

    // The unused 2'b11 main-state code behaves as IDLE everywhere.
    function automatic main_state_e norm_main(input logic [1:0] raw);
        case (raw)
            2'b01:   return s_EXPOSURE;
            2'b10:   return s_READOUT;
            default: return s_IDLE;
        endcase
    endfunction

    function automatic sub_state_e step_code(input step_e s);
        case (s)
            STEP_NRE1_A, STEP_NRE1_B: return s_NRE_1;
            STEP_ADC_1:               return s_ADC_1;
            STEP_GAP:                 return s_NOTHING;
            STEP_NRE2_A, STEP_NRE2_B: return s_NRE_2;
            STEP_ADC_2:               return s_ADC_2;
            STEP_END:                 return s_END;
            default:                  return s_INIT;
        endcase
    endfunction

endpackage

// File: rtl/readout_sequencer_phase_timer.sv
// Loadable down-counter timing one readout phase; expire_o is high once the
// count has reached zero and stays there until the next load.
module phase_timer #(
    parameter int unsigned P_MAX_CYCLES = 4,
    localparam int unsigned W = $clog2(P_MAX_CYCLES + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Exposure countdown and readout sub-FSM sequencing, driven by the main FSM state.
// step        | meaning
// STEP_INIT   | not in readout, code INIT
// STEP_NRE1_A | first NRE_1 window
// STEP_ADC_1  | ADC_1 conversion
// STEP_NRE1_B | second NRE_1 window
// STEP_GAP    | NOTHING gap
// STEP_NRE2_A | first NRE_2 window
// STEP_ADC_2  | ADC_2 conversion
// STEP_NRE2_B | second NRE_2 window
// STEP_END    | readout complete, held until main FSM leaves READOUT
module readout_sequencer
    import ex_control_pkg::*;
#(
    parameter int unsigned P_NRE_CYCLES = 2,
    parameter int unsigned P_ADC_CYCLES = 4,
    parameter int unsigned P_GAP_CYCLES = 1,
    parameter logic [4:0]  P_EXP_RESET  = 5'd30
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [1:0] i_Main_FSM,
    input  logic [4:0] i_Exp_time,
    input  logic       i_Exp_load,
    output logic [4:0] o_count_time,
    output logic [2:0] o_RD_FSM,
    output logic       o_Busy,
    output logic       o_Done
);

    localparam int unsigned MAX_NA  = (P_NRE_CYCLES > P_ADC_CYCLES) ? P_NRE_CYCLES : P_ADC_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_NA > P_GAP_CYCLES) ? MAX_NA : P_GAP_CYCLES;
    localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);

    main_state_e       main_q, main_prev_q;
    logic [4:0]        exp_q, count_q;
    step_e             step_q, step_d;
    sub_state_e        rd_q;
    logic              busy_q, done_q;
    logic              tmr_load, tmr_expire;
    logic [TIMER_W-1:0] tmr_value;

    // Timer is loaded with duration-1 so a phase lasts exactly its duration.
    function automatic logic [TIMER_W-1:0] step_reload(input step_e s);
        case (s)
            STEP_NRE1_A, STEP_NRE1_B,
            STEP_NRE2_A, STEP_NRE2_B: return TIMER_W'(P_NRE_CYCLES - 1);
            STEP_ADC_1, STEP_ADC_2:   return TIMER_W'(P_ADC_CYCLES - 1);
            STEP_GAP:                 return TIMER_W'(P_GAP_CYCLES - 1);
            default:                  return '0;
        endcase
    endfunction

    always_comb begin
        step_d    = step_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (main_q != s_READOUT) begin
            step_d   = STEP_INIT;
            tmr_load = 1'b1;
        end else if (main_prev_q != s_READOUT) begin
            step_d = STEP_NRE1_A;
        end else if (step_q != STEP_INIT && step_q != STEP_END && tmr_expire) begin
            step_d = step_e'(4'(step_q) + 4'd1);
        end
        if (step_d != step_q) begin
            tmr_load  = 1'b1;
            tmr_value = step_reload(step_d);
        end
    end

    phase_timer #(
        .P_MAX_CYCLES(MAX_CYC)
    ) u_phase_timer (
        .clk_i   (i_Clock),
        .rst_i   (i_Reset),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .expire_o(tmr_expire)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            main_q      <= s_IDLE;
            main_prev_q <= s_IDLE;
            exp_q       <= P_EXP_RESET;
            count_q     <= P_EXP_RESET;
            step_q      <= STEP_INIT;
            rd_q        <= s_INIT;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            main_q      <= norm_main(i_Main_FSM);
            main_prev_q <= main_q;
            if (i_Exp_load && norm_main(i_Main_FSM) == s_IDLE) begin
                exp_q <= i_Exp_time;
            end
            case (main_q)
                s_EXPOSURE: begin
                    if (main_prev_q != s_EXPOSURE) begin
                        count_q <= exp_q;
                    end else if (count_q != 5'd0) begin
                        count_q <= count_q - 5'd1;
                    end
                end
                s_IDLE:  count_q <= exp_q;
                default: count_q <= count_q;
            endcase
            step_q <= step_d;
            rd_q   <= step_code(step_d);
            busy_q <= (step_d != STEP_INIT) && (step_d != STEP_END);
            done_q <= (step_d == STEP_END) && (step_q != STEP_END);
        end
    end

    assign o_count_time = count_q;
    assign o_RD_FSM     = rd_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;

endmodule

// File: doc/readout_sequencer.md
# readout_sequencer

Timing source for the pixel-array exposure controller. Follows the main FSM state (IDLE/EXPOSURE/READOUT), generates the exposure countdown (`count_time`) and steps the readout sub-FSM code (`RD_FSM`) through NRE/ADC phases with programmable durations. Sits between the register/config layer and the exposure controller: its `o_count_time` and `o_RD_FSM` drive the controller's `i_count_time` and `i_RD_FSM`, and the controller's `o_Main_FSM` feeds back into `i_Main_FSM`.

## Interface
- `P_NRE_CYCLES`, 2: cycles per NRE_1/NRE_2 phase (≥1)
- `P_ADC_CYCLES`, 4: cycles per ADC_1/ADC_2 phase (≥1)
- `P_GAP_CYCLES`, 1: cycles in NOTHING phase (≥1)
- `P_EXP_RESET`, 30: reset value of the exposure-time register (5-bit)
- `i_Clock`  in  1  single clock, rising edge
- `i_Reset`  in  1  synchronous, active-high reset
- `i_Main_FSM`  in  2  main FSM state: 00 IDLE, 01 EXPOSURE, 10 READOUT, 11 invalid (treated as IDLE)
- `i_Exp_time`  in  5  exposure time in cycles
- `i_Exp_load`  in  1  latch `i_Exp_time`; honoured only when `i_Main_FSM`==IDLE
- `o_count_time`  out  5  exposure countdown to controller
- `o_RD_FSM`  out  3  readout sub-state code
- `o_Busy`  out  1  high while `o_RD_FSM` in NRE_1..ADC_2
- `o_Done`  out  1  one-cycle pulse on the first cycle of END

## Operation
- Reset values: `r_exp`=P_EXP_RESET, `o_count_time`=P_EXP_RESET, `o_RD_FSM`=INIT (000), `o_Busy`=0, `o_Done`=0, step index 0, phase counter 0, previous-main-state register = IDLE.
- Entry detection: a registered copy of `i_Main_FSM`; entry to X means current==X and previous!=X.
- Exposure register: `i_Exp_load`=1 in IDLE → `r_exp`<=`i_Exp_time`; ignored in any other state. Value 0 is legal.
- Exposure countdown: in IDLE, `o_count_time` tracks `r_exp`. On entry to EXPOSURE it loads `r_exp`; each following EXPOSURE cycle it decrements, saturating at 0 (never wraps to 31). In READOUT it holds its value.
- Readout sub-FSM (step index 0..8 → code): 0 INIT(000), 1 NRE_1(001), 2 ADC_1(010), 3 NRE_1(001), 4 NOTHING(011), 5 NRE_2(100), 6 ADC_2(101), 7 NRE_2(100), 8 END(110).
- INIT held whenever `i_Main_FSM`!=READOUT. On entry to READOUT → step 1. Each of steps 1–7 lasts its parameter duration, then advances. END holds until `i_Main_FSM` leaves READOUT, then INIT the next cycle.
- Abort: `i_Main_FSM` leaves READOUT during steps 1–7 → INIT next cycle, phase counter cleared, no `o_Done`.
- Re-entry to READOUT always restarts at step 1.
- Reset mid-operation forces all reset values on the next edge, regardless of other inputs.

## Timing
- All outputs registered; no combinational input→output path.
- READOUT entry sampled at edge t → `o_RD_FSM`=NRE_1 after edge t+1.
- Readout length NRE_1 through NOTHING-to-ADC_2 end: 4·P_NRE + 2·P_ADC + P_GAP cycles (defaults: 17). END appears at t+1+17; `o_Done` high for exactly that one cycle.
- EXPOSURE entry sampled at t → `o_count_time`=`r_exp` at t+1, `r_exp`−k at t+1+k, 0 from t+1+`r_exp` onward.
- `o_Busy` changes in the same cycle as `o_RD_FSM`.

## Structure
- Shared package `ex_control_pkg`: main-state encodings (s_IDLE, s_EXPOSURE, s_READOUT) and sub-state encodings (s_INIT…s_END). The exposure controller and its testbench use the same package.
- One sub-module `phase_timer`: loadable down-counter, width from max duration parameter, `load`/`value` in, `expire` pulse out. Instantiated once, reloaded on each step change.

## Test plan
- Reset held 2 cycles with `i_Main_FSM`=READOUT → `o_RD_FSM`=000, `o_count_time`=30, `o_Busy`=0, `o_Done`=0.
- IDLE, load 5; EXPOSURE for 8 cycles → `o_count_time` 5,4,3,2,1,0,0,0. Load 7 during EXPOSURE → ignored, `r_exp` stays 5.
- Defaults, READOUT entry at t → code sequence 001×2, 010×4, 001×2, 011×1, 100×2, 101×4, 100×2, then 110 at t+18 with `o_Done`=1 for one cycle; returning to IDLE → 000 next cycle.
- Abort: drop to IDLE during ADC_1 → 000 next cycle, no `o_Done`. Re-enter READOUT → restarts at NRE_1 for full 2 cycles.
- `i_Main_FSM`=11 during READOUT → treated as IDLE, abort as above; load 0 then EXPOSURE → `o_count_time`=0 at t+1.
- Synchronous reset asserted in ADC_2 → next cycle all outputs at reset values; `r_exp` back to 30.
